// File: rtl/ps2_rx_if.sv
// Event handshake between the PS/2 receiver and the matrix keyboard stage.
interface ps2_rx_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_release,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_release,
        output ev_ready
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin sync, clock deglitch, 11-bit frame
// deserialiser, E0/F0/E1 prefix folding and a show-ahead event FIFO.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 60000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     ps2_clk,
    input  logic     ps2_dat,
    ps2_rx_if.master ev,
    output logic     frame_err,
    output logic     overflow
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           clk_f, clk_f_d;
    logic [FCW-1:0] fcnt;
    logic           strobe;

    state_t         state;
    logic [2:0]     bcnt;
    logic [TW-1:0]  tcnt;
    logic [7:0]     shreg;
    logic           par;
    logic           byte_rdy;
    logic [7:0]     rx_byte;

    logic [2:0]     skip;
    logic           ext_f, rel_f;
    logic [9:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push, pop, do_write;

    // Two-flop synchronisers on both raw pins
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Deglitch: clk_f follows the synced clock only after FILTER_LEN equal samples
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            fcnt    <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s2 != clk_f) begin
                if (fcnt == FCW'(FILTER_LEN - 1)) begin
                    clk_f <= clk_s2;
                    fcnt  <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign strobe = clk_f_d & ~clk_f;

    // Frame FSM with inter-bit timeout; byte_rdy and frame_err are one-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bcnt      <= '0;
            tcnt      <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            byte_rdy  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
            if (strobe || state == IDLE) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
            if (state != IDLE && !strobe && tcnt == TW'(TIMEOUT - 1)) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                tcnt      <= '0;
            end else if (strobe) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state <= DATA;
                            bcnt  <= '0;
                        end
                    end
                    DATA: begin
                        shreg <= {dat_s2, shreg[7:1]};
                        if (bcnt == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        if (dat_s2 && ^{par, shreg}) begin
                            byte_rdy <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A received byte becomes an event unless it is a prefix, error code or inside a Pause sequence
    always_comb begin
        push = 1'b0;
        if (byte_rdy && skip == '0) begin
            case (rx_byte)
                8'hE1, 8'hE0, 8'hF0, 8'h00, 8'hFF: push = 1'b0;
                default:                           push = 1'b1;
            endcase
        end
        pop      = ev.ev_valid & ev.ev_ready;
        do_write = push & ((count != CW'(FIFO_DEPTH)) | pop);
    end

    // Prefix state tracking and FIFO storage; a pop frees the head slot in time for a same-cycle push
    always_ff @(posedge clk) begin
        if (reset) begin
            skip     <= '0;
            ext_f    <= 1'b0;
            rel_f    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & ~do_write;
            if (byte_rdy) begin
                if (skip != '0) begin
                    skip <= skip - 1'b1;
                end else begin
                    case (rx_byte)
                        8'hE1: skip  <= 3'd7;
                        8'hE0: ext_f <= 1'b1;
                        8'hF0: rel_f <= 1'b1;
                        default: begin
                            ext_f <= 1'b0;
                            rel_f <= 1'b0;
                        end
                    endcase
                end
            end
            if (do_write) begin
                mem[wr_ptr] <= {ext_f, rel_f, rx_byte};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Show-ahead head presentation, zeroed while empty
    always_comb begin
        ev.ev_valid   = (count != '0);
        ev.ev_code    = '0;
        ev.ev_ext     = 1'b0;
        ev.ev_release = 1'b0;
        if (count != '0) begin
            ev.ev_code    = mem[rd_ptr][7:0];
            ev.ev_release = mem[rd_ptr][8];
            ev.ev_ext     = mem[rd_ptr][9];
        end
    end
endmodule
